// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the oversampled multi-command SPI slave.
// The CRC helpers are only used when SPI_SLV_CRC_EN is defined.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_WAIT = 3'd4
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Default command codes, listed channel 0 first (leftmost in the flat table).
  localparam logic [7:0] CMD_CH0 = 8'hC7;
  localparam logic [7:0] CMD_CH1 = 8'hB8;
  localparam logic [7:0] CMD_CH2 = 8'h87;
  localparam logic [7:0] CMD_CH3 = 8'hF8;
  localparam logic [31:0] DEF_CMD_TABLE = {CMD_CH0, CMD_CH1, CMD_CH2, CMD_CH3};

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/spi_slave_mcmd_if.sv
// SPI pins plus the channel-word and status bundle of spi_slave_mcmd.
interface spi_slave_mcmd_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     cs_n;
  logic                     scl;
  logic                     si;
  logic                     so;
  logic                     so_oe;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [IDX_W-1:0]         frame_idx;
  logic                     frame_done;
  logic                     frame_err;
  logic                     busy;

  modport master (
    output cs_n, scl, si, ch_data,
    input  so, so_oe, frame_idx, frame_done, frame_err, busy
  );

  modport slave (
    input  cs_n, scl, si, ch_data,
    output so, so_oe, frame_idx, frame_done, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall detect on the
// synchronised level. RST_VAL should be the idle level of the pin.
module spi_slave_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // next-state of the synchroniser chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // synchroniser and edge-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/spi_slave_mcmd.sv
// Oversampled SPI slave: receives a command, returns the matched channel word MSB first.
// Define SPI_SLV_CRC_EN to append a CRC-8 of the word after the data bits.
module spi_slave_mcmd
  import spi_slave_pkg::*;
#(
  parameter int                      NUM_CH    = 3,
  parameter int                      CMD_W     = 8,
  parameter int                      DATA_W    = 32,
  parameter logic [NUM_CH*CMD_W-1:0] CMD_TABLE = DEF_CMD_TABLE[31 -: NUM_CH*CMD_W],
  parameter bit                      CPOL      = 1'b0,
  parameter bit                      CPHA      = 1'b0
) (
  input logic             sys_clk,
  input logic             sys_rst,
  spi_slave_mcmd_if.slave bus
);
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CMD_CNT_W = $clog2(CMD_W + 1);
  localparam int OUT_CNT_W = $clog2(DATA_W + 1);

  logic scl_rise_s, scl_fall_s, scl_lvl_unused;
  logic cs_rise_s, cs_fall_s, cs_lvl_unused;
  logic si_s, si_rise_unused, si_fall_unused;
  logic sample_edge_s, shift_edge_s;

  spi_slave_sync_edge #(.RST_VAL(CPOL)) u_sync_scl (
    .clk(sys_clk), .rst(sys_rst), .d(bus.scl),
    .q(scl_lvl_unused), .rise(scl_rise_s), .fall(scl_fall_s)
  );
  spi_slave_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(sys_clk), .rst(sys_rst), .d(bus.cs_n),
    .q(cs_lvl_unused), .rise(cs_rise_s), .fall(cs_fall_s)
  );
  spi_slave_sync_edge #(.RST_VAL(1'b0)) u_sync_si (
    .clk(sys_clk), .rst(sys_rst), .d(bus.si),
    .q(si_s), .rise(si_rise_unused), .fall(si_fall_unused)
  );

  // Modes 0 and 3 sample on the rising scl edge, modes 1 and 2 on the falling one.
  assign sample_edge_s = (CPOL ^ CPHA) ? scl_fall_s : scl_rise_s;
  assign shift_edge_s  = (CPOL ^ CPHA) ? scl_rise_s : scl_fall_s;

  state_e               state_q, state_d;
  logic [CMD_W-1:0]     cmd_sr_q, cmd_sr_d;
  logic [CMD_CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                 so_q, so_d, so_oe_q, so_oe_d, busy_q, busy_d;
  logic                 frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [IDX_W-1:0]     frame_idx_q, frame_idx_d;
`ifdef SPI_SLV_CRC_EN
  logic [7:0]           crc_q, crc_d;
  logic [3:0]           crc_cnt_q, crc_cnt_d;
`endif

  logic                 hit_s;
  logic [IDX_W-1:0]     hit_idx_s;
  logic [DATA_W-1:0]    snap_s;

  // parallel command match; scanning downwards lets the lowest index win
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    snap_s    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cmd_sr_q == CMD_TABLE[(NUM_CH-1-i)*CMD_W +: CMD_W]) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
        snap_s    = bus.ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // frame FSM next-state and datapath
  always_comb begin
    state_d      = state_q;
    cmd_sr_d     = cmd_sr_q;
    cmd_cnt_d    = cmd_cnt_q;
    tx_sr_d      = tx_sr_q;
    out_cnt_d    = out_cnt_q;
    so_d         = so_q;
    frame_idx_d  = frame_idx_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef SPI_SLV_CRC_EN
    crc_d        = crc_q;
    crc_cnt_d    = crc_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        so_d = 1'b0;
        if (cs_fall_s) begin
          state_d   = ST_CMD;
          cmd_cnt_d = CMD_CNT_W'(CMD_W);
          cmd_sr_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (cs_rise_s) begin
          frame_err_d = 1'b1;
          so_d        = 1'b0;
          state_d     = ST_IDLE;
        end else if (cmd_cnt_q == '0) begin
          if (hit_s) begin
            tx_sr_d     = snap_s;
            frame_idx_d = hit_idx_s;
            out_cnt_d   = OUT_CNT_W'(DATA_W);
            state_d     = ST_DATA;
`ifdef SPI_SLV_CRC_EN
            crc_d       = 8'h00;
`endif
          end else begin
            frame_err_d = 1'b1;
            so_d        = 1'b0;
            state_d     = ST_WAIT;
          end
        end else if (sample_edge_s) begin
          cmd_sr_d  = {cmd_sr_q[CMD_W-2:0], si_s};
          cmd_cnt_d = cmd_cnt_q - CMD_CNT_W'(1);
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (cs_rise_s) begin
          frame_err_d = 1'b1;
          so_d        = 1'b0;
          state_d     = ST_IDLE;
        end else if (out_cnt_q == '0) begin
          // leave on the sample edge so the master still captures the last bit
          if (sample_edge_s) begin
`ifdef SPI_SLV_CRC_EN
            crc_cnt_d = 4'd8;
            state_d   = ST_CRC;
`else
            frame_done_d = 1'b1;
            so_d         = 1'b0;
            state_d      = ST_WAIT;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else if (shift_edge_s) begin
          so_d      = tx_sr_q[DATA_W-1];
          tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
          out_cnt_d = out_cnt_q - OUT_CNT_W'(1);
`ifdef SPI_SLV_CRC_EN
          crc_d     = crc8_step(crc_q, tx_sr_q[DATA_W-1]);
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef SPI_SLV_CRC_EN
      ST_CRC: begin
        if (cs_rise_s) begin
          frame_err_d = 1'b1;
          so_d        = 1'b0;
          state_d     = ST_IDLE;
        end else if (crc_cnt_q == 4'd0) begin
          if (sample_edge_s) begin
            frame_done_d = 1'b1;
            so_d         = 1'b0;
            state_d      = ST_WAIT;
          end else begin
            state_d = ST_CRC;
          end
        end else if (shift_edge_s) begin
          so_d      = crc_q[7];
          crc_d     = {crc_q[6:0], 1'b0};
          crc_cnt_d = crc_cnt_q - 4'd1;
        end else begin
          state_d = ST_CRC;
        end
      end
`endif
      ST_WAIT: begin
        so_d = 1'b0;
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        so_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    so_oe_d = (state_d == ST_DATA) || (state_d == ST_CRC);
    busy_d  = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      cmd_sr_q     <= '0;
      cmd_cnt_q    <= '0;
      tx_sr_q      <= '0;
      out_cnt_q    <= '0;
      so_q         <= 1'b0;
      so_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_idx_q  <= '0;
`ifdef SPI_SLV_CRC_EN
      crc_q        <= 8'h00;
      crc_cnt_q    <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_sr_q     <= cmd_sr_d;
      cmd_cnt_q    <= cmd_cnt_d;
      tx_sr_q      <= tx_sr_d;
      out_cnt_q    <= out_cnt_d;
      so_q         <= so_d;
      so_oe_q      <= so_oe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_idx_q  <= frame_idx_d;
`ifdef SPI_SLV_CRC_EN
      crc_q        <= crc_d;
      crc_cnt_q    <= crc_cnt_d;
`endif
    end
  end

  assign bus.so         = so_q;
  assign bus.so_oe      = so_oe_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_idx  = frame_idx_q;
endmodule
